// File: rtl/csr_pkg.sv
// Shared CSR numbers, field positions, exception codes and the masked-write helper
// for the csr_regfile block.
package csr_pkg;

   localparam logic [13:0] CSR_CRMD   = 14'h000;
   localparam logic [13:0] CSR_PRMD   = 14'h001;
   localparam logic [13:0] CSR_ECFG   = 14'h004;
   localparam logic [13:0] CSR_ESTAT  = 14'h005;
   localparam logic [13:0] CSR_ERA    = 14'h006;
   localparam logic [13:0] CSR_BADV   = 14'h007;
   localparam logic [13:0] CSR_EENTRY = 14'h00c;
   localparam logic [13:0] CSR_SAVE0  = 14'h030;
   localparam logic [13:0] CSR_TID    = 14'h040;
   localparam logic [13:0] CSR_TCFG   = 14'h041;
   localparam logic [13:0] CSR_TVAL   = 14'h042;
   localparam logic [13:0] CSR_TICLR  = 14'h044;

   localparam int unsigned CRMD_IE_BIT      = 2;
   localparam int unsigned ESTAT_IS_HW_LSB  = 2;
   localparam int unsigned ESTAT_IS_TI_BIT  = 11;
   localparam int unsigned ESTAT_IS_IPI_BIT = 12;
   localparam int unsigned EENTRY_VA_LSB    = 6;

   // LIE bit 10 has no interrupt source behind it.
   localparam logic [12:0] ECFG_LIE_MASK = 13'h1bff;

   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_ADE = 6'h08;
   localparam logic [5:0] ECODE_ALE = 6'h09;
   localparam logic [5:0] ECODE_SYS = 6'h0b;
   localparam logic [5:0] ECODE_BRK = 6'h0c;
   localparam logic [5:0] ECODE_INE = 6'h0d;

   function automatic logic [31:0] mask_write(input logic [31:0] old_v,
                                              input logic [31:0] wmask,
                                              input logic [31:0] wvalue);
      return (wmask & wvalue) | (~wmask & old_v);
   endfunction

endpackage

// File: rtl/csr_timer.sv
// Countdown timer: TCFG/TVAL state, reload/decrement counter and the sticky
// timer interrupt bit (ESTAT.IS[11]) with TICLR clear.
module csr_timer #(
   parameter int unsigned TIMER_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tcfg_we,
   input  logic        ticlr_we,
   input  logic [31:0] wdata,
   output logic [31:0] tcfg_rvalue,
   output logic [31:0] tval_rvalue,
   output logic        timer_int
);

   logic [TIMER_W-1:0] tcfg_q;
   logic [TIMER_W-1:0] tcfg_new;
   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;
   logic               ti_q;
   logic               en;
   logic               periodic;

   assign tcfg_new = wdata[TIMER_W-1:0];
   assign en       = tcfg_q[0];
   assign periodic = tcfg_q[1];

   // All-ones is the parking value of a finished one-shot count.
   always_comb begin
      cnt_d = cnt_q;
      if (tcfg_we) begin
         cnt_d = {tcfg_new[TIMER_W-1:2], 2'b00};
      end else if (en && (cnt_q != '1)) begin
         if ((cnt_q == '0) && periodic) begin
            cnt_d = {tcfg_q[TIMER_W-1:2], 2'b00};
         end else begin
            cnt_d = cnt_q - TIMER_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tcfg_q <= '0;
         cnt_q  <= '0;
         ti_q   <= 1'b0;
      end else begin
         if (tcfg_we) begin
            tcfg_q <= tcfg_new;
         end
         cnt_q <= cnt_d;
         if (en && (cnt_q == '0)) begin
            ti_q <= 1'b1;
         end else if (ticlr_we && wdata[0]) begin
            ti_q <= 1'b0;
         end
      end
   end

   assign tcfg_rvalue = 32'(tcfg_q);
   assign tval_rvalue = 32'(cnt_q);
   assign timer_int   = ti_q;

endmodule

// File: rtl/csr_regfile.sv
// LoongArch CSR file: CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY/SAVEn plus interrupt pending.
// Define CSR_TIMER_EN to build the TID/TCFG/TVAL/TICLR timer (csr_timer).
module csr_regfile
   import csr_pkg::*;
#(
   parameter int unsigned TIMER_W    = 32,
   parameter int unsigned HW_INT_NUM = 8,
   parameter int unsigned SAVE_NUM   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  csr_re,
   input  logic [13:0]           csr_num,
   output logic [31:0]           csr_rvalue,
   input  logic                  csr_we,
   input  logic [31:0]           csr_wmask,
   input  logic [31:0]           csr_wvalue,
   input  logic                  wb_ex,
   input  logic [31:0]           wb_pc,
   input  logic [31:0]           wb_vaddr,
   input  logic [5:0]            wb_ecode,
   input  logic [8:0]            wb_esubcode,
   input  logic                  ertn_flush,
   input  logic [HW_INT_NUM-1:0] hw_int_in,
   input  logic                  ipi_int_in,
   output logic [31:0]           ex_entry,
   output logic [31:0]           era_out,
   output logic                  has_int
);

   logic [1:0]            plv_q;
   logic                  ie_q;
   logic [1:0]            pplv_q;
   logic                  pie_q;
   logic [12:0]           lie_q;
   logic [1:0]            is_sw_q;
   logic [HW_INT_NUM-1:0] is_hw_q;
   logic                  is_ipi_q;
   logic                  is_ti;
   logic [5:0]            ecode_q;
   logic [8:0]            esubcode_q;
   logic [31:0]           era_q;
   logic [31:0]           badv_q;
   logic [25:0]           eentry_q;
   logic [31:0]           save_q [SAVE_NUM];
   logic [12:0]           is_all;
   logic [31:0]           rdata;
   logic [31:0]           wdata;
   logic [31:0]           tid_rd;
   logic [31:0]           tcfg_rd;
   logic [31:0]           tval_rd;
   logic                  csr_wr;

   // Exceptions and ERTN own the cycle; a coincident CSR write is dropped.
   assign csr_wr = csr_we & ~wb_ex & ~ertn_flush;

   always_comb begin
      is_all                                 = '0;
      is_all[1:0]                            = is_sw_q;
      is_all[ESTAT_IS_HW_LSB +: HW_INT_NUM]  = is_hw_q;
      is_all[ESTAT_IS_TI_BIT]                = is_ti;
      is_all[ESTAT_IS_IPI_BIT]               = is_ipi_q;
   end

   always_comb begin
      rdata = '0;
      case (csr_num)
         CSR_CRMD:   rdata = {27'b0, 1'b1, ie_q, plv_q};
         CSR_PRMD:   rdata = {29'b0, pie_q, pplv_q};
         CSR_ECFG:   rdata = {19'b0, lie_q};
         CSR_ESTAT:  rdata = {1'b0, esubcode_q, ecode_q, 3'b0, is_all};
         CSR_ERA:    rdata = era_q;
         CSR_BADV:   rdata = badv_q;
         CSR_EENTRY: rdata = {eentry_q, 6'b0};
         CSR_TID:    rdata = tid_rd;
         CSR_TCFG:   rdata = tcfg_rd;
         CSR_TVAL:   rdata = tval_rd;
         default:    rdata = '0;
      endcase
      for (int unsigned i = 0; i < SAVE_NUM; i++) begin
         if (csr_num == CSR_SAVE0 + 14'(i)) rdata = save_q[i];
      end
   end

   // Merging against the addressed register's read image keeps read-only bits intact.
   assign wdata      = mask_write(rdata, csr_wmask, csr_wvalue);
   assign csr_rvalue = csr_re ? rdata : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         plv_q      <= '0;
         ie_q       <= 1'b0;
         pplv_q     <= '0;
         pie_q      <= 1'b0;
         lie_q      <= '0;
         is_sw_q    <= '0;
         is_hw_q    <= '0;
         is_ipi_q   <= 1'b0;
         ecode_q    <= '0;
         esubcode_q <= '0;
         era_q      <= '0;
         badv_q     <= '0;
         eentry_q   <= '0;
         for (int unsigned i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
      end else begin
         is_hw_q  <= hw_int_in;
         is_ipi_q <= ipi_int_in;
         if (wb_ex) begin
            pplv_q     <= plv_q;
            pie_q      <= ie_q;
            plv_q      <= '0;
            ie_q       <= 1'b0;
            era_q      <= wb_pc;
            ecode_q    <= wb_ecode;
            esubcode_q <= wb_esubcode;
            if ((wb_ecode == ECODE_ADE) || (wb_ecode == ECODE_ALE)) badv_q <= wb_vaddr;
         end else if (ertn_flush) begin
            plv_q <= pplv_q;
            ie_q  <= pie_q;
         end else if (csr_wr) begin
            case (csr_num)
               CSR_CRMD: begin
                  plv_q <= wdata[1:0];
                  ie_q  <= wdata[CRMD_IE_BIT];
               end
               CSR_PRMD: begin
                  pplv_q <= wdata[1:0];
                  pie_q  <= wdata[2];
               end
               CSR_ECFG:   lie_q    <= wdata[12:0] & ECFG_LIE_MASK;
               CSR_ESTAT:  is_sw_q  <= wdata[1:0];
               CSR_ERA:    era_q    <= wdata;
               CSR_BADV:   badv_q   <= wdata;
               CSR_EENTRY: eentry_q <= wdata[31:EENTRY_VA_LSB];
               default: ;
            endcase
            for (int unsigned i = 0; i < SAVE_NUM; i++) begin
               if (csr_num == CSR_SAVE0 + 14'(i)) save_q[i] <= wdata;
            end
         end
      end
   end

`ifdef CSR_TIMER_EN
   logic [31:0] tid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tid_q <= '0;
      end else if (csr_wr && (csr_num == CSR_TID)) begin
         tid_q <= wdata;
      end
   end

   assign tid_rd = tid_q;

   csr_timer #(
      .TIMER_W (TIMER_W)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .tcfg_we     (csr_wr && (csr_num == CSR_TCFG)),
      .ticlr_we    (csr_wr && (csr_num == CSR_TICLR)),
      .wdata       (wdata),
      .tcfg_rvalue (tcfg_rd),
      .tval_rvalue (tval_rd),
      .timer_int   (is_ti)
   );
`else
   logic [TIMER_W-1:0] tval_zero;

   assign tval_zero = '0;
   assign tid_rd    = '0;
   assign tcfg_rd   = '0;
   assign tval_rd   = 32'(tval_zero);
   assign is_ti     = 1'b0;
`endif

   assign has_int  = ie_q & |(is_all & lie_q);
   assign ex_entry = {eentry_q, 6'b0};
   assign era_out  = era_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed and randomized self-checking bench for csr_regfile.
module tb_csr_regfile;
   import csr_pkg::*;

   localparam int unsigned TIMER_W    = 32;
   localparam int unsigned HW_INT_NUM = 8;
   localparam int unsigned SAVE_NUM   = 4;
   localparam int          NREG       = 10;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  csr_re;
   logic [13:0]           csr_num;
   logic [31:0]           csr_rvalue;
   logic                  csr_we;
   logic [31:0]           csr_wmask;
   logic [31:0]           csr_wvalue;
   logic                  wb_ex;
   logic [31:0]           wb_pc;
   logic [31:0]           wb_vaddr;
   logic [5:0]            wb_ecode;
   logic [8:0]            wb_esubcode;
   logic                  ertn_flush;
   logic [HW_INT_NUM-1:0] hw_int_in;
   logic                  ipi_int_in;
   logic [31:0]           ex_entry;
   logic [31:0]           era_out;
   logic                  has_int;

   int checks = 0;
   int errors = 0;

   // Reference state: architectural value of each modelled CSR plus sampled IRQ lines.
   logic [13:0]           nums [NREG];
   logic [31:0]           wmsk [NREG];
   logic [31:0]           mdl  [NREG];
   logic [HW_INT_NUM-1:0] hw_seen;
   logic                  ipi_seen;

   csr_regfile #(
      .TIMER_W    (TIMER_W),
      .HW_INT_NUM (HW_INT_NUM),
      .SAVE_NUM   (SAVE_NUM)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .csr_re      (csr_re),
      .csr_num     (csr_num),
      .csr_rvalue  (csr_rvalue),
      .csr_we      (csr_we),
      .csr_wmask   (csr_wmask),
      .csr_wvalue  (csr_wvalue),
      .wb_ex       (wb_ex),
      .wb_pc       (wb_pc),
      .wb_vaddr    (wb_vaddr),
      .wb_ecode    (wb_ecode),
      .wb_esubcode (wb_esubcode),
      .ertn_flush  (ertn_flush),
      .hw_int_in   (hw_int_in),
      .ipi_int_in  (ipi_int_in),
      .ex_entry    (ex_entry),
      .era_out     (era_out),
      .has_int     (has_int)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      if (reset) begin
         hw_seen  = '0;
         ipi_seen = 1'b0;
      end else begin
         hw_seen  = hw_int_in;
         ipi_seen = ipi_int_in;
      end
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [13:0] n, output logic [31:0] v);
      csr_num = n;
      csr_re  = 1'b1;
      #1;
      v      = csr_rvalue;
      csr_re = 1'b0;
   endtask

   task automatic chk_rd(input string tag, input logic [13:0] n, input logic [31:0] exp);
      logic [31:0] v;
      rd(n, v);
      chk(tag, v, exp);
   endtask

   task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
      csr_num    = n;
      csr_we     = 1'b1;
      csr_wmask  = m;
      csr_wvalue = v;
      step();
      csr_we = 1'b0;
   endtask

   task automatic ex(input logic [31:0] pc, input logic [31:0] va, input logic [5:0] code,
                     input logic [8:0] sub);
      wb_ex       = 1'b1;
      wb_pc       = pc;
      wb_vaddr    = va;
      wb_ecode    = code;
      wb_esubcode = sub;
      step();
      wb_ex = 1'b0;
   endtask

   task automatic ertn();
      ertn_flush = 1'b1;
      step();
      ertn_flush = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   function automatic logic [31:0] estat_exp();
      return mdl[3] | (32'(hw_seen) << 2) | (32'(ipi_seen) << 12);
   endfunction

   initial begin
      logic [31:0] v;
      logic [31:0] m;
      logic [31:0] d;
      logic [31:0] pc;
      logic [31:0] va;
      logic [5:0]  code;
      logic [8:0]  sub;
      logic        is_exp;
      logic        set;
      int          idx;
      int          op;

      reset = 1'b0; csr_re = 1'b0; csr_num = '0; csr_we = 1'b0; csr_wmask = '0;
      csr_wvalue = '0; wb_ex = 1'b0; wb_pc = '0; wb_vaddr = '0; wb_ecode = '0;
      wb_esubcode = '0; ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
      hw_seen = '0; ipi_seen = 1'b0;

      // Reset values.
      do_reset();
      chk_rd("reset_crmd", CSR_CRMD, 32'h8);
      chk_rd("reset_ecfg", CSR_ECFG, 32'h0);
      chk_rd("reset_estat", CSR_ESTAT, 32'h0);
      chk_rd("reset_tcfg", CSR_TCFG, 32'h0);
      chk_rd("reset_tval", CSR_TVAL, 32'h0);
      chk_rd("unimpl_read", 14'h002, 32'h0);
      csr_num = CSR_CRMD;
      #1;
      chk("re_low_zero", csr_rvalue, 32'h0);
      chk("reset_has_int", {31'b0, has_int}, 32'h0);

      // Exception entry and return.
      wr(CSR_CRMD, 32'hffff_ffff, 32'h7);
      chk_rd("crmd_write", CSR_CRMD, 32'hf);
      ex(32'h1c00_0100, 32'hdead_beef, ECODE_SYS, 9'h5);
      chk_rd("ex_crmd", CSR_CRMD, 32'h8);
      chk_rd("ex_prmd", CSR_PRMD, 32'h7);
      chk_rd("ex_era", CSR_ERA, 32'h1c00_0100);
      chk("ex_era_out", era_out, 32'h1c00_0100);
      rd(CSR_ESTAT, v);
      chk("ex_ecode", (v >> 16) & 32'h3f, 32'hb);
      chk("ex_esubcode", (v >> 22) & 32'h1ff, 32'h5);
      ertn();
      chk_rd("ertn_crmd", CSR_CRMD, 32'hf);

      // BADV capture only for address exceptions.
      ex(32'h1c00_0200, 32'h0000_1234, ECODE_ALE, 9'h0);
      chk_rd("badv_ale", CSR_BADV, 32'h0000_1234);
      ex(32'h1c00_0300, 32'h0000_5678, ECODE_SYS, 9'h0);
      chk_rd("badv_sys_keep", CSR_BADV, 32'h0000_1234);
      ex(32'h1c00_0400, 32'h0000_9abc, ECODE_ADE, 9'h0);
      chk_rd("badv_ade", CSR_BADV, 32'h0000_9abc);

      // Masked writes and read-only bits.
      wr(CSR_ERA, 32'h0000_ffff, 32'haaaa_5555);
      chk_rd("era_masked", CSR_ERA, 32'h1c00_5555);
      wr(CSR_EENTRY, 32'hffff_ffff, 32'hffff_ffff);
      chk_rd("eentry_ro_low", CSR_EENTRY, 32'hffff_ffc0);
      chk("ex_entry", ex_entry, 32'hffff_ffc0);
      wr(CSR_ECFG, 32'hffff_ffff, 32'h0000_1fff);
      chk_rd("ecfg_bit10", CSR_ECFG, 32'h0000_1bff);

      // Hardware interrupt with IE set, then with IE clear.
      wr(CSR_ECFG, 32'hffff_ffff, 32'h4);
      wr(CSR_CRMD, 32'hffff_ffff, 32'h4);
      hw_int_in = 8'h01;
      chk("int_before_sample", {31'b0, has_int}, 32'h0);
      step();
      chk("int_ie1", {31'b0, has_int}, 32'h1);
      hw_int_in = '0;
      step();
      chk("int_drop", {31'b0, has_int}, 32'h0);
      wr(CSR_CRMD, 32'hffff_ffff, 32'h0);
      hw_int_in = 8'h01;
      step();
      chk("int_ie0", {31'b0, has_int}, 32'h0);
      hw_int_in = '0;
      step();

`ifdef CSR_TIMER_EN
      // One-shot, InitVal=2: counts 8..0, wraps to all-ones and stops.
      wr(CSR_TCFG, 32'hffff_ffff, 32'h9);
      for (int c = 1; c <= 13; c++) begin
         rd(CSR_TVAL, v);
         chk($sformatf("oneshot_tval_c%0d", c), v, (c <= 9) ? 32'(9 - c) : 32'hffff_ffff);
         rd(CSR_ESTAT, v);
         chk($sformatf("oneshot_ti_c%0d", c), (v >> 11) & 32'h1, (c >= 10) ? 32'h1 : 32'h0);
         step();
      end
      chk_rd("tcfg_read", CSR_TCFG, 32'h9);
      chk_rd("ticlr_reads0", CSR_TICLR, 32'h0);
      wr(CSR_TICLR, 32'hffff_ffff, 32'h1);
      rd(CSR_ESTAT, v);
      chk("ticlr_clear", (v >> 11) & 32'h1, 32'h0);

      // Periodic: clear in cycle 10, clear coincides with the next set in cycle 18.
      wr(CSR_TCFG, 32'hffff_ffff, 32'hb);
      is_exp = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         rd(CSR_TVAL, v);
         chk($sformatf("periodic_tval_c%0d", c), v, 32'(8 - ((c - 1) % 9)));
         rd(CSR_ESTAT, v);
         chk($sformatf("periodic_ti_c%0d", c), (v >> 11) & 32'h1, {31'b0, is_exp});
         set = ((8 - ((c - 1) % 9)) == 0);
         if (c == 10 || c == 18) begin
            wr(CSR_TICLR, 32'h1, 32'h1);
            is_exp = set;
         end else begin
            step();
            is_exp = set | is_exp;
         end
      end
      wr(CSR_TCFG, 32'hffff_ffff, 32'h0);
      wr(CSR_TICLR, 32'h1, 32'h1);
      rd(CSR_ESTAT, v);
      chk("timer_off_ti", (v >> 11) & 32'h1, 32'h0);
      wr(CSR_TID, 32'hffff_ffff, 32'h1234_5678);
      chk_rd("tid_rw", CSR_TID, 32'h1234_5678);
      wmsk[9] = 32'hffff_ffff;
`else
      wr(CSR_TID, 32'hffff_ffff, 32'h1234_5678);
      chk_rd("tid_absent", CSR_TID, 32'h0);
      wr(CSR_TCFG, 32'hffff_ffff, 32'hb);
      for (int c = 0; c < 12; c++) step();
      chk_rd("tcfg_absent", CSR_TCFG, 32'h0);
      chk_rd("tval_absent", CSR_TVAL, 32'h0);
      rd(CSR_ESTAT, v);
      chk("ti_absent", (v >> 11) & 32'h1, 32'h0);
      wmsk[9] = 32'h0;
`endif

      // Randomized phase against the reference model.
      nums[0] = CSR_CRMD;   wmsk[0] = 32'h7;
      nums[1] = CSR_PRMD;   wmsk[1] = 32'h7;
      nums[2] = CSR_ECFG;   wmsk[2] = 32'h1bff;
      nums[3] = CSR_ESTAT;  wmsk[3] = 32'h3;
      nums[4] = CSR_ERA;    wmsk[4] = 32'hffff_ffff;
      nums[5] = CSR_BADV;   wmsk[5] = 32'hffff_ffff;
      nums[6] = CSR_EENTRY; wmsk[6] = 32'hffff_ffc0;
      nums[7] = CSR_SAVE0;  wmsk[7] = 32'hffff_ffff;
      nums[8] = CSR_SAVE0 + 14'(SAVE_NUM - 1); wmsk[8] = 32'hffff_ffff;
      nums[9] = CSR_TID;
      for (int i = 0; i < NREG; i++) mdl[i] = '0;
      do_reset();
      mdl[0] = 32'h8;
      pc = $urandom; va = $urandom;
      ex(pc, va, ECODE_ADE, 9'h1a5);
      mdl[1] = 32'h0;
      mdl[3] = (32'(ECODE_ADE) << 16) | (32'h1a5 << 22);
      mdl[4] = pc;
      mdl[5] = va;
      for (int i = 0; i < NREG; i++) begin
         d = $urandom;
         wr(nums[i], 32'hffff_ffff, d);
         mdl[i] = (mdl[i] & ~wmsk[i]) | (d & wmsk[i]);
      end

      for (int it = 0; it < 300; it++) begin
         hw_int_in  = ($urandom_range(0, 3) == 0) ? HW_INT_NUM'($urandom) : '0;
         ipi_int_in = ($urandom_range(0, 5) == 0);
         op = $urandom_range(0, 9);
         if (op == 0) begin
            pc = $urandom; va = $urandom;
            code = 6'($urandom_range(0, 15)); sub = 9'($urandom);
            mdl[1] = mdl[0] & 32'h7;
            mdl[0] = 32'h8;
            mdl[4] = pc;
            mdl[3] = (mdl[3] & 32'h3) | (32'(code) << 16) | (32'(sub) << 22);
            if (code == ECODE_ADE || code == ECODE_ALE) mdl[5] = va;
            ex(pc, va, code, sub);
         end else if (op == 1) begin
            mdl[0] = 32'h8 | (mdl[1] & 32'h7);
            ertn();
         end else begin
            idx = $urandom_range(0, NREG - 1);
            m = $urandom; d = $urandom;
            mdl[idx] = (mdl[idx] & ~(m & wmsk[idx])) | (d & m & wmsk[idx]);
            wr(nums[idx], m, d);
         end
         idx = $urandom_range(0, NREG - 1);
         rd(nums[idx], v);
         chk($sformatf("rand_reg%0d_it%0d", idx, it), v, (idx == 3) ? estat_exp() : mdl[idx]);
         rd(CSR_ESTAT, v);
         chk($sformatf("rand_estat_it%0d", it), v, estat_exp());
         d = estat_exp() & mdl[2] & 32'h1fff;
         chk($sformatf("rand_has_int_it%0d", it), {31'b0, has_int},
             {31'b0, mdl[0][2] & (d != 0)});
         chk($sformatf("rand_era_out_it%0d", it), era_out, mdl[4]);
         chk($sformatf("rand_ex_entry_it%0d", it), ex_entry, mdl[6]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
